// File: rtl/relm_fp_pkg.sv
// relm_fp_pkg: float format constants, b-word field positions and prefix-OR helper
package relm_fp_pkg;
    localparam int EW       = 8;
    localparam int FW       = 23;
    localparam int GW       = 7;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam int SIGN_B   = 31;
    localparam int EXP_MSB  = 30;
    localparam int INF_B    = 22;
    localparam int ZERO_B   = 21;
    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } fp_class_t;
    function automatic logic [30:0] relm_lower(input logic [30:0] x);
        logic [30:0] r;
        r[30] = x[30];
        for (int i = 29; i >= 0; i--) r[i] = x[i] | r[i+1];
        return r;
    endfunction
endpackage

// File: rtl/relm_fnorm_lzc.sv
// relm_fnorm_lzc: 31-bit leading-zero count, 31 when the input is all zero
module relm_fnorm_lzc (
    input  logic [30:0] a,
    output logic [4:0]  lzc
);
    import relm_fp_pkg::*;
    logic [30:0] p;
    logic [30:0] oh;
    // isolate the leading one, then OR-encode its distance from bit 30
    always_comb begin
        p = relm_lower(a);
        oh = a & ~(p >> 1);
        lzc = {5{~p[0]}};
        for (int i = 0; i < 31; i++) lzc = lzc | (oh[i] ? 5'(30 - i) : 5'd0);
    end
endmodule

// File: rtl/relm_custom_fnorm.sv
// relm_custom_fnorm: 3-stage normalise/round/pack of relm_custom raw results to IEEE single
module relm_custom_fnorm
    import relm_fp_pkg::*;
#(
    parameter int WD = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_in,
    output logic          ready_out,
    input  logic [WD-1:0] a_in,
    input  logic [WD-1:0] b_in,
    output logic          valid_out,
    input  logic          ready_in,
    output logic [WD-1:0] q_out,
    output logic [2:0]    flags_out
);
    localparam int XW = EW + 2;
    localparam logic signed [XW-1:0] E_MAX = XW'(EXP_MAX);
    logic v1, v2, v3, adv;
    logic a_zero, unused_b;
    logic [4:0] lzc;
    fp_class_t cls;
    logic [WD-1:0] s1_a;
    logic [EW-1:0] s1_exp;
    logic [4:0] s1_lzc;
    logic s1_sign;
    fp_class_t s1_cls;
    logic [XW-1:0] ex;
    logic [WD-1:0] n_m;
    logic [XW-1:0] n_e;
    logic [WD-1:0] s2_m;
    logic signed [XW-1:0] s2_e;
    logic s2_sign;
    fp_class_t s2_cls;
    logic g, s, up, ovf, unf;
    logic [FW:0] fr;
    logic signed [XW-1:0] e_r;
    logic [WD-1:0] n_q;
    logic [2:0] n_f;

    assign adv = ~v3 | ready_in;
    assign ready_out = adv;
    assign valid_out = v3;
    assign unused_b = ^b_in[ZERO_B-1:0];

    relm_fnorm_lzc u_lzc (
        .a  (a_in[WD-2:0]),
        .lzc(lzc)
    );

    // classify the incoming result; an all-zero mantissa is an exact zero
    always_comb begin
        a_zero = a_in == '0;
        cls.nan = b_in[INF_B] & b_in[ZERO_B];
        cls.inf = b_in[INF_B] & ~b_in[ZERO_B];
        cls.zero = (b_in[ZERO_B] & ~b_in[INF_B]) | a_zero;
    end

    // stage valids: the whole pipe moves as one on adv
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (adv) begin
            v1 <= valid_in;
            v2 <= v1;
            v3 <= v2;
        end
    end

    // S1 capture: mantissa, exponent, class and leading-zero count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a <= '0;
            s1_exp <= '0;
            s1_lzc <= '0;
            s1_sign <= 1'b0;
            s1_cls <= '0;
        end else if (adv) begin
            s1_a <= a_in;
            s1_exp <= b_in[EXP_MSB -: EW];
            s1_lzc <= lzc;
            s1_sign <= b_in[SIGN_B] & ~(a_zero & ~b_in[INF_B]);
            s1_cls <= cls;
        end
    end

    // normalise so the hidden one sits at bit 30, keeping the shifted-out bit sticky
    always_comb begin
        ex = {2'b00, s1_exp};
        n_m = s1_a[WD-1] ? ((s1_a >> 1) | {{(WD-1){1'b0}}, s1_a[0]}) : s1_a << s1_lzc;
        n_e = s1_a[WD-1] ? ex + XW'(1) : ex - XW'(s1_lzc);
    end

    // S2 register: normalised mantissa and wide signed exponent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_m <= '0;
            s2_e <= '0;
            s2_sign <= 1'b0;
            s2_cls <= '0;
        end else if (adv) begin
            s2_m <= n_m;
            s2_e <= n_e;
            s2_sign <= s1_sign;
            s2_cls <= s1_cls;
        end
    end

    // round to nearest even, then pick the result by class and exponent range
    always_comb begin
        g = s2_m[GW-1];
        s = |s2_m[GW-2:0];
        up = g & (s | s2_m[GW]);
        fr = {1'b0, s2_m[WD-3:GW]} + (FW+1)'(up);
        e_r = s2_e + (fr[FW] ? XW'(1) : XW'(0));
        ovf = e_r >= E_MAX;
        unf = e_r[XW-1] | (e_r == '0);
        n_q = s2_cls.nan  ? QNAN
            : s2_cls.inf  ? {s2_sign, {EW{1'b1}}, {FW{1'b0}}}
            : s2_cls.zero ? {s2_sign, {(WD-1){1'b0}}}
            : ovf         ? {s2_sign, {EW{1'b1}}, {FW{1'b0}}}
            : unf         ? {s2_sign, {(WD-1){1'b0}}}
            :               {s2_sign, e_r[EW-1:0], fr[FW-1:0]};
        n_f = (s2_cls.nan | s2_cls.inf | s2_cls.zero) ? 3'b000
            : ovf ? 3'b110
            : unf ? 3'b101
            : {g | s, 2'b00};
    end

    // S3 output register, held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_out <= '0;
            flags_out <= '0;
        end else if (adv) begin
            q_out <= n_q;
            flags_out <= n_f;
        end
    end
endmodule

// File: tb/tb_relm_custom_fnorm.sv
// tb_relm_custom_fnorm: scoreboard bench with a value-level float reference model
module tb_relm_custom_fnorm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid_in = 1'b0;
    logic ready_in = 1'b1;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic ready_out, valid_out;
    logic [31:0] q_out;
    logic [2:0] flags_out;
    logic [34:0] sb[$];
    logic [34:0] mon_e;
    int checks = 0;
    int errors = 0;
    bit rand_ready = 0;
    int lat, acc, sel;
    logic [31:0] ra, rb, r;
    logic [31:0] bp_a[4];
    logic [31:0] bp_b[4];
    logic [34:0] bp_e[4];

    relm_custom_fnorm dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .a_in     (a_in),
        .b_in     (b_in),
        .valid_out(valid_out),
        .ready_in (ready_in),
        .q_out    (q_out),
        .flags_out(flags_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mkb(input logic s, input logic [7:0] e, input logic inf, input logic zero);
        return {s, e, inf, zero, 21'd0};
    endfunction

    // value-level reference: a is a fixed-point significand with weight 2^-30, scaled by 2^(exp-127)
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
        logic sg;
        int e, p, sh;
        logic [63:0] kept, rem, half;
        logic inx;
        sg = b[31];
        if (b[22] && b[21]) return {32'h7FC00000, 3'b000};
        if (b[22]) return {sg, 8'hFF, 23'd0, 3'b000};
        if (a == 0) return 35'd0;
        if (b[21]) return {sg, 31'd0, 3'b000};
        p = 31;
        while (!a[p]) p--;
        e = int'(b[30:23]) + p - 30;
        inx = 1'b0;
        if (p > 23) begin
            sh = p - 23;
            kept = 64'(a) >> sh;
            rem = 64'(a) & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            inx = rem != 0;
            if (rem > half || (rem == half && kept[0])) kept = kept + 64'd1;
        end else kept = 64'(a) << (23 - p);
        if (kept == (64'd1 << 24)) begin
            kept = kept >> 1;
            e++;
        end
        if (e >= 255) return {sg, 8'hFF, 23'd0, 3'b110};
        if (e <= 0) return {sg, 31'd0, 3'b101};
        return {sg, 8'(e), kept[22:0], inx, 2'b00};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [34:0] exp_v);
        bit done;
        done = 0;
        a_in = a;
        b_in = b;
        valid_in = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (ready_out) begin
                sb.push_back(exp_v);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: ready_out=%b expected 1", ready_out);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_outstanding", 32'(sb.size()), 32'd0);
    endtask

    // monitor: a transfer happens on the next edge whenever valid_out & ready_in
    always @(negedge clk) begin
        if (rst_n && valid_out && ready_in) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got q=%h with nothing expected", q_out);
            end else begin
                mon_e = sb.pop_front();
                chk("q_out", q_out, mon_e[34:3]);
                chk("flags_out", 32'(flags_out), 32'(mon_e[2:0]));
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) ready_in = $urandom_range(0, 3) != 0;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid_out", 32'(valid_out), 32'd0);
        chk("reset_q_out", q_out, 32'd0);
        chk("reset_flags_out", 32'(flags_out), 32'd0);
        chk("reset_ready_out", 32'(ready_out), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(32'h80000000, mkb(0, 8'h7F, 0, 0), {32'h40000000, 3'b000});
        valid_in = 1'b0;
        lat = 0;
        while (!valid_out && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'd3);
        @(posedge clk);
        #1;
        send(32'h40000040, mkb(0, 8'h7F, 0, 0), {32'h3F800000, 3'b100});
        send(32'h400000C0, mkb(0, 8'h7F, 0, 0), {32'h3F800002, 3'b100});
        send(32'h7FFFFFC0, mkb(0, 8'h7F, 0, 0), {32'h40000000, 3'b100});
        send(32'h80000000, mkb(0, 8'hFE, 0, 0), {32'h7F800000, 3'b110});
        send(32'h00000000, mkb(1, 8'h7F, 0, 0), {32'h00000000, 3'b000});
        send(32'h00000080, mkb(0, 8'h7F, 0, 0), {32'h34000000, 3'b000});
        send(32'h00000080, mkb(0, 8'h10, 0, 0), {32'h00000000, 3'b101});
        send(32'h40000000, mkb(1, 8'h7F, 1, 1), {32'h7FC00000, 3'b000});
        send(32'h40000000, mkb(1, 8'h7F, 1, 0), {32'hFF800000, 3'b000});
        valid_in = 1'b0;
        drain();
        rand_ready = 1;
        for (int k = 0; k < 300; k++) begin
            sel = $urandom_range(0, 5);
            r = $urandom;
            ra = sel == 0 ? 32'd0
               : sel == 1 ? r >> $urandom_range(0, 31)
               : sel == 2 ? r | 32'h80000000
               : sel == 3 ? (r & 32'h7FFFFFFF) | 32'h40000000
               : sel == 4 ? (r & 32'h7FFFFF80) | 32'h40000040
               : r;
            rb = {1'($urandom), 8'($urandom_range(0, 255)), $urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0, 21'($urandom)};
            send(ra, rb, model(ra, rb));
        end
        valid_in = 1'b0;
        drain();
        rand_ready = 0;
        @(posedge clk);
        #1;
        ready_in = 1'b0;
        bp_a = '{32'h40000040, 32'h7FFFFFC0, 32'h00000080, 32'h40000000};
        bp_b = '{mkb(0, 8'h7F, 0, 0), mkb(0, 8'h7F, 0, 0), mkb(0, 8'h7F, 0, 0), mkb(1, 8'h7F, 1, 0)};
        bp_e = '{{32'h3F800000, 3'b100}, {32'h40000000, 3'b100}, {32'h34000000, 3'b000}, {32'hFF800000, 3'b000}};
        acc = 0;
        a_in = bp_a[0];
        b_in = bp_b[0];
        valid_in = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ready_out && valid_in && acc < 4) begin
                sb.push_back(bp_e[acc]);
                acc++;
            end
            @(posedge clk);
            #1;
            if (acc < 4) begin
                a_in = bp_a[acc];
                b_in = bp_b[acc];
            end else valid_in = 1'b0;
        end
        chk("bp_accepted", 32'(acc), 32'd3);
        chk("bp_ready_out", 32'(ready_out), 32'd0);
        chk("bp_valid_out", 32'(valid_out), 32'd1);
        ready_in = 1'b1;
        if (acc < 4) send(bp_a[3], bp_b[3], bp_e[3]);
        valid_in = 1'b0;
        drain();
        ready_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ra = $urandom | 32'h40000000;
            rb = mkb(0, 8'h80, 0, 0);
            send(ra, rb, model(ra, rb));
        end
        valid_in = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midstall_valid_out", 32'(valid_out), 32'd0);
        chk("midstall_ready_out", 32'(ready_out), 32'd1);
        chk("midstall_q_out", q_out, 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_in = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_reset_valid_out", 32'(valid_out), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
